my_bus_master: RTL and testbench

- Initiator end of the myBus protocol. It drives the bus command inputs of the bus slave and monitors the slave's outputs.
- Converts host single-beat read/write commands into wrCmd/rdCmd beats and returns read data from rdResp.
- Answers slave-originated vdoReq/smapReq with fixed-length vdoResp/smapResp write bursts sourced from two data ports.
- Sits between the host/test logic and the bus slave on the same clock.

---
 rtl/my_bus_master.sv | 173 +++++++++++++++++
 tb/tb_my_bus_master.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/my_bus_master.sv
// myBus initiator: host single-beat commands to wrCmd/rdCmd beats, and fixed-length vdo/smap response bursts.
// Optional statistics counters are built when MYBUS_MST_STATS_EN is defined.
module my_bus_master #(
  parameter int BURST_LEN  = 4,
  parameter int RD_TIMEOUT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmdValid,
  output logic       cmdReady,
  input  logic       cmdWrite,
  input  logic [7:0] cmdAddr,
  input  logic [7:0] cmdData,
  output logic       rspValid,
  output logic [7:0] rspData,
  output logic       rspErr,
  input  logic [7:0] vdoData,
  output logic       vdoTake,
  input  logic [7:0] smapData,
  output logic       smapTake,
  output logic [2:0] busModeOut,
  output logic [7:0] busAddrOut,
  output logic [7:0] busDataOut,
  output logic       busSelOut,
  input  logic [2:0] busModeIn,
  input  logic [7:0] busAddrIn,
  input  logic [7:0] busDataIn,
  input  logic       busSelIn,
  output logic [7:0] statTimeouts,
  output logic [15:0] statBursts
);

  typedef enum logic [2:0] {IDLE, WR, RD_CMD, RD_WAIT, SVC} state_t;

  localparam logic [4:0] LAST_BEAT  = 5'(BURST_LEN - 1);
  localparam logic [7:0] PTR_STEP   = 8'(BURST_LEN);
  localparam logic [7:0] TO_LAST    = 8'(RD_TIMEOUT - 1);
  localparam logic [2:0] M_WR       = 3'b000;
  localparam logic [2:0] M_RD       = 3'b001;
  localparam logic [2:0] M_RDRESP   = 3'b010;
  localparam logic [2:0] M_VDOREQ   = 3'b011;
  localparam logic [2:0] M_VDORESP  = 3'b100;
  localparam logic [2:0] M_SMAPREQ  = 3'b101;
  localparam logic [2:0] M_SMAPRESP = 3'b110;

  state_t     state;
  logic       vdo_pend, smap_pend, svc_smap;
  logic [7:0] vdo_ptr, smap_ptr, svc_ptr, cnt;
  logic [4:0] beat;
  logic       rd_resp, vdo_req, smap_req, timeout_evt, burst_evt;
  logic       unused_addr_in;

  assign rd_resp        = busSelIn && (busModeIn == M_RDRESP);
  assign vdo_req        = busSelIn && (busModeIn == M_VDOREQ);
  assign smap_req       = busSelIn && (busModeIn == M_SMAPREQ);
  assign timeout_evt    = (state == RD_WAIT) && !rd_resp && (cnt == TO_LAST);
  assign burst_evt      = (state == SVC) && (beat == LAST_BEAT);
  assign svc_ptr        = svc_smap ? smap_ptr : vdo_ptr;
  assign cmdReady       = !rst && (state == IDLE) && !vdo_pend && !smap_pend;
  assign unused_addr_in = ^busAddrIn;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      vdo_pend   <= 1'b0;
      smap_pend  <= 1'b0;
      svc_smap   <= 1'b0;
      vdo_ptr    <= '0;
      smap_ptr   <= '0;
      cnt        <= '0;
      beat       <= '0;
      busModeOut <= '0;
      busAddrOut <= '0;
      busDataOut <= '0;
      busSelOut  <= 1'b0;
      rspValid   <= 1'b0;
      rspData    <= '0;
      rspErr     <= 1'b0;
      vdoTake    <= 1'b0;
      smapTake   <= 1'b0;
    end else begin
      busSelOut <= 1'b0;
      rspValid  <= 1'b0;
      rspErr    <= 1'b0;
      rspData   <= '0;
      vdoTake   <= 1'b0;
      smapTake  <= 1'b0;
      case (state)
        IDLE: begin
          if (vdo_pend) begin
            vdo_pend <= 1'b0;
            svc_smap <= 1'b0;
            beat     <= '0;
            vdoTake  <= 1'b1;
            state    <= SVC;
          end else if (smap_pend) begin
            smap_pend <= 1'b0;
            svc_smap  <= 1'b1;
            beat      <= '0;
            smapTake  <= 1'b1;
            state     <= SVC;
          end else if (cmdValid) begin
            busSelOut  <= 1'b1;
            busAddrOut <= cmdAddr;
            if (cmdWrite) begin
              busModeOut <= M_WR;
              busDataOut <= cmdData;
              rspValid   <= 1'b1;
              state      <= WR;
            end else begin
              busModeOut <= M_RD;
              busDataOut <= '0;
              state      <= RD_CMD;
            end
          end
        end
        WR: state <= IDLE;
        RD_CMD: begin
          cnt   <= '0;
          state <= RD_WAIT;
        end
        RD_WAIT: begin
          cnt <= cnt + 8'd1;
          // A response landing on the final wait cycle still wins over the timeout.
          if (rd_resp) begin
            rspValid <= 1'b1;
            rspData  <= busDataIn;
            state    <= IDLE;
          end else if (timeout_evt) begin
            rspValid <= 1'b1;
            rspErr   <= 1'b1;
            state    <= IDLE;
          end
        end
        SVC: begin
          busSelOut  <= 1'b1;
          busModeOut <= svc_smap ? M_SMAPRESP : M_VDORESP;
          busAddrOut <= svc_ptr + {3'b000, beat};
          busDataOut <= svc_smap ? smapData : vdoData;
          if (burst_evt) begin
            state <= IDLE;
            if (svc_smap) smap_ptr <= smap_ptr + PTR_STEP;
            else          vdo_ptr  <= vdo_ptr + PTR_STEP;
          end else begin
            beat     <= beat + 5'd1;
            vdoTake  <= !svc_smap;
            smapTake <= svc_smap;
          end
        end
        default: state <= IDLE;
      endcase
      // Request capture overrides the clear on SVC entry so a same-cycle repeat is not lost.
      if (vdo_req)  vdo_pend  <= 1'b1;
      if (smap_req) smap_pend <= 1'b1;
    end
  end

`ifdef MYBUS_MST_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      statTimeouts <= '0;
      statBursts   <= '0;
    end else begin
      if (timeout_evt && (statTimeouts != 8'hFF)) statTimeouts <= statTimeouts + 8'd1;
      if (burst_evt) statBursts <= statBursts + 16'd1;
    end
  end
`else
  assign statTimeouts = '0;
  assign statBursts   = '0;
`endif

endmodule

// File: tb/tb_my_bus_master.sv
// Bench for my_bus_master: a small live myBus slave model plus beat/response scoreboards.
// Handshake: a host command transfers on the rising edge where cmd_valid && cmd_ready are both high.
module tb_my_bus_master;

  localparam int BL = 4;
`ifdef MYBUS_MST_STATS_EN
  localparam bit STATS_ON = 1'b1;
`else
  localparam bit STATS_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr, cmd_data;
  logic        rsp_valid, rsp_err;
  logic [7:0]  rsp_data;
  logic [7:0]  vdo_data, smap_data;
  logic        vdo_take, smap_take;
  logic [2:0]  bus_mode_out, bus_mode_in;
  logic [7:0]  bus_addr_out, bus_data_out, bus_addr_in, bus_data_in;
  logic        bus_sel_out, bus_sel_in;
  logic [7:0]  stat_timeouts;
  logic [15:0] stat_bursts;

  my_bus_master #(.BURST_LEN(BL), .RD_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst),
    .cmdValid(cmd_valid), .cmdReady(cmd_ready), .cmdWrite(cmd_write),
    .cmdAddr(cmd_addr), .cmdData(cmd_data),
    .rspValid(rsp_valid), .rspData(rsp_data), .rspErr(rsp_err),
    .vdoData(vdo_data), .vdoTake(vdo_take), .smapData(smap_data), .smapTake(smap_take),
    .busModeOut(bus_mode_out), .busAddrOut(bus_addr_out), .busDataOut(bus_data_out),
    .busSelOut(bus_sel_out),
    .busModeIn(bus_mode_in), .busAddrIn(bus_addr_in), .busDataIn(bus_data_in),
    .busSelIn(bus_sel_in),
    .statTimeouts(stat_timeouts), .statBursts(stat_bursts)
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  int last_cmd_cyc = 0;

  logic [18:0] exp_q[$];   // {mode, addr, data} per bus beat
  logic [16:0] rsp_q[$];   // {err, data, latency from command beat}

  logic [7:0] mem[256];
  logic [7:0] ref_mem[256];
  logic [7:0] vdo_mem[256];
  logic       rd_stage, req_vdo, req_smap, accepted;
  logic [7:0] rd_addr_s, vptr, sptr, vdo_base, smap_base;
  int         vdo_idx, smap_idx, exp_bursts;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock step: the slave model reacts to the cycle that just ended.
  task automatic tick();
    logic       sel_b;
    logic [2:0] mode_b;
    logic [7:0] addr_b, data_b;
    sel_b    = bus_sel_out;
    mode_b   = bus_mode_out;
    addr_b   = bus_addr_out;
    data_b   = bus_data_out;
    accepted = cmd_valid && cmd_ready;
    @(posedge clk);
    #1;
    cyc++;
    if (sel_b && mode_b == 3'b000) mem[addr_b] = data_b;
    if (sel_b && mode_b == 3'b100) vdo_mem[addr_b] = data_b;
    bus_sel_in  = 1'b0;
    bus_mode_in = 3'b000;
    bus_data_in = 8'h00;
    bus_addr_in = 8'($urandom_range(0, 255));
    if (req_vdo) begin
      bus_sel_in = 1'b1; bus_mode_in = 3'b011; req_vdo = 1'b0;
    end else if (req_smap) begin
      bus_sel_in = 1'b1; bus_mode_in = 3'b101; req_smap = 1'b0;
    end else if (rd_stage) begin
      bus_sel_in = 1'b1; bus_mode_in = 3'b010; bus_data_in = mem[rd_addr_s];
    end
    rd_stage  = !rst && sel_b && mode_b == 3'b001;
    rd_addr_s = addr_b;
    vdo_data  = vdo_base + 8'(vdo_idx);
    if (vdo_take) vdo_idx++;
    smap_data = smap_base + 8'(smap_idx);
    if (smap_take) smap_idx++;
  endtask

  // driver tasks
  task automatic do_cmd(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int n;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = a; cmd_data = d;
    accepted = 1'b0;
    n = 0;
    while (!accepted && n < 200) begin
      tick();
      n++;
    end
    if (!accepted) check("cmd_accept_timeout", 32'(accepted), 32'd1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || rsp_q.size() != 0 || !cmd_ready) && n < 400) begin
      tick();
      n++;
    end
    if (n >= 400) check("idle_timeout", 32'(exp_q.size() + rsp_q.size()), 32'd0);
  endtask

  task automatic push_vdo_burst();
    vdo_idx = 0;
    vdo_base = 8'h30;
    for (int k = 0; k < BL; k++) exp_q.push_back({3'b100, 8'(vptr + 8'(k)), 8'(8'h30 + k)});
    vptr = vptr + 8'(BL);
    exp_bursts++;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    tick();
    tick();
    exp_q.delete();
    rsp_q.delete();
    vptr = 8'h00; sptr = 8'h00; exp_bursts = 0;
    req_vdo = 1'b0; req_smap = 1'b0; rd_stage = 1'b0;
    rst = 1'b0;
    tick();
  endtask

  // scoreboard: pop expected beats and responses as the DUT produces them
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_sel_out) begin
        if (exp_q.size() == 0) check("beat_extra", 32'(exp_q.size()), 32'd1);
        else check("beat", {13'd0, bus_mode_out, bus_addr_out, bus_data_out}, {13'd0, exp_q.pop_front()});
        if (bus_mode_out == 3'b000 || bus_mode_out == 3'b001) last_cmd_cyc = cyc;
      end
      if (rsp_valid) begin
        if (rsp_q.size() == 0) check("rsp_extra", 32'(rsp_q.size()), 32'd1);
        else check("rsp", {15'd0, rsp_err, rsp_data, 8'(cyc - last_cmd_cyc)}, {15'd0, rsp_q.pop_front()});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [7:0] a, d;
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = 8'h00; cmd_data = 8'h00;
    vdo_data = 8'h00; smap_data = 8'h00;
    bus_mode_in = 3'b000; bus_addr_in = 8'h00; bus_data_in = 8'h00; bus_sel_in = 1'b0;
    req_vdo = 1'b0; req_smap = 1'b0; rd_stage = 1'b0; rd_addr_s = 8'h00;
    vptr = 8'h00; sptr = 8'h00; vdo_base = 8'h30; smap_base = 8'h50;
    vdo_idx = 0; smap_idx = 0; exp_bursts = 0; accepted = 1'b0;
    for (int i = 0; i < 256; i++) begin
      mem[i] = 8'h00; ref_mem[i] = 8'h00; vdo_mem[i] = 8'h00;
    end

    // reset state
    tick(); tick(); tick();
    check("rst_bus_sel", 32'(bus_sel_out), 32'd0);
    check("rst_bus_mode", 32'(bus_mode_out), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_take", 32'({vdo_take, smap_take}), 32'd0);
    check("rst_stats", 32'({stat_timeouts, stat_bursts}), 32'd0);
    rst = 1'b0;
    tick();
    check("ready_after_rst", 32'(cmd_ready), 32'd1);

    // write 0x10 = 0xA5, response in the beat cycle
    exp_q.push_back({3'b000, 8'h10, 8'hA5});
    rsp_q.push_back({1'b0, 8'h00, 8'd0});
    ref_mem[8'h10] = 8'hA5;
    do_cmd(1'b1, 8'h10, 8'hA5);
    check("wr_beat_sel", 32'(bus_sel_out), 32'd1);
    check("wr_rsp_same_cycle", 32'({rsp_valid, rsp_err}), 32'b10);
    tick();
    check("wr_ready_back", 32'(cmd_ready), 32'd1);
    check("wr_sel_single", 32'(bus_sel_out), 32'd0);

    // read back through the live slave, rspValid 3 cycles after the rdCmd beat
    exp_q.push_back({3'b001, 8'h10, 8'h00});
    rsp_q.push_back({1'b0, 8'hA5, 8'd3});
    do_cmd(1'b0, 8'h10, 8'h00);
    wait_idle();

    // random write/read pairs
    for (int i = 0; i < 4; i++) begin
      a = 8'($urandom_range(8'h40, 8'h7F));
      d = 8'($urandom_range(0, 255));
      ref_mem[a] = d;
      exp_q.push_back({3'b000, a, d});
      rsp_q.push_back({1'b0, 8'h00, 8'd0});
      do_cmd(1'b1, a, d);
      wait_idle();
      exp_q.push_back({3'b001, a, 8'h00});
      rsp_q.push_back({1'b0, ref_mem[a], 8'd3});
      do_cmd(1'b0, a, 8'h00);
      wait_idle();
    end

    // two vdo bursts land in the slave's vdo memory
    push_vdo_burst();
    req_vdo = 1'b1;
    wait_idle();
    push_vdo_burst();
    req_vdo = 1'b1;
    wait_idle();
    for (int i = 0; i < 8; i++) check("vdo_mem", 32'(vdo_mem[i]), 32'(8'h30 + (i % 4)));

    // vdo, smap and a host command all waiting: bursts first, then the command
    push_vdo_burst();
    smap_idx = 0;
    for (int k = 0; k < BL; k++) exp_q.push_back({3'b110, 8'(sptr + 8'(k)), 8'(8'h50 + k)});
    sptr = sptr + 8'(BL);
    exp_bursts++;
    exp_q.push_back({3'b000, 8'h20, 8'h5A});
    rsp_q.push_back({1'b0, 8'h00, 8'd0});
    ref_mem[8'h20] = 8'h5A;
    req_vdo = 1'b1;
    req_smap = 1'b1;
    tick();
    tick();
    check("ready_low_pending", 32'(cmd_ready), 32'd0);
    do_cmd(1'b1, 8'h20, 8'h5A);
    check("bursts_before_cmd", 32'(exp_q.size()), 32'd1);
    wait_idle();

    // rdResp collides with a vdoReq at the slave: read times out
    exp_q.push_back({3'b001, 8'h22, 8'h00});
    rsp_q.push_back({1'b1, 8'h00, 8'd17});
    do_cmd(1'b0, 8'h22, 8'h00);
    tick();
    push_vdo_burst();
    req_vdo = 1'b1;
    wait_idle();
    check("stat_timeouts", 32'(stat_timeouts), STATS_ON ? 32'd1 : 32'd0);
    check("stat_bursts_a", 32'(stat_bursts), STATS_ON ? 32'(exp_bursts) : 32'd0);

    // pointer wrap over 65 bursts
    apply_reset();
    for (int b = 0; b < 65; b++) begin
      push_vdo_burst();
      req_vdo = 1'b1;
      wait_idle();
    end
    check("stat_bursts_wrap", 32'(stat_bursts), STATS_ON ? 32'd65 : 32'd0);

    // reset in the middle of a burst
    push_vdo_burst();
    req_vdo = 1'b1;
    for (int n = 0; n < 20 && !bus_sel_out; n++) tick();
    check("midburst_beat_seen", 32'(bus_sel_out), 32'd1);
    rst = 1'b1;
    tick();
    check("midburst_sel_off", 32'(bus_sel_out), 32'd0);
    check("midburst_outs_zero", 32'({bus_mode_out, bus_addr_out, vdo_take, rsp_valid}), 32'd0);
    tick();
    exp_q.delete();
    rsp_q.delete();
    vptr = 8'h00; exp_bursts = 0; req_vdo = 1'b0; rd_stage = 1'b0;
    rst = 1'b0;
    tick();
    push_vdo_burst();
    req_vdo = 1'b1;
    wait_idle();
    check("stat_bursts_after_rst", 32'(stat_bursts), STATS_ON ? 32'd1 : 32'd0);

    // final report
    tick();
    check("beats_drained", 32'(exp_q.size()), 32'd0);
    check("rsps_drained", 32'(rsp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
